// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI master slice.
package spi_pkg;

  localparam int SPI_DATA_W_DEF   = 8;
  localparam int SPI_HALF_DIV_DEF = 50;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: one-cycle tick every HALF_DIV clk_in cycles while
// enabled; the counter is held at zero whenever the enable is low.
module sclk_tick_gen #(
  parameter int HALF_DIV = 50
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W   = $clog2(HALF_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: reset is synchronous (sampled only on the clock edge), and state flops use
  // non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one word per start request.
// Define SPI_LOOPBACK_EN to feed mosi back into the receive path instead of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W_DEF,
  parameter int HALF_DIV = SPI_HALF_DIV_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  if (DATA_W < 2)   begin : g_bad_data_w   $error("DATA_W must be at least 2");   end
  if (HALF_DIV < 2) begin : g_bad_half_div $error("HALF_DIV must be at least 2"); end

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tick;
  logic              rx_in;

  // State changes only happen on a tick, where the counter wraps to zero, and the
  // counter is held clear in IDLE, so every state is entered with a zero count.
  sclk_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (state_q != IDLE),
    .tick   (tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_in       = tx_sr_q[DATA_W-1];
`else
  assign rx_in = miso;
`endif

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d   = TRANSFER;
          bit_cnt_d = '0;
        end
      end
      TRANSFER: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_in};
          end else if (bit_cnt_q == LAST_BIT) begin
            // Last falling edge: keep the LSB on mosi through HOLD.
            state_d = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = IDLE;
          tx_sr_d    = '0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    cs_n_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;
  assign mosi     = tx_sr_q[DATA_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 8, sets bits per transfer; SHALL be at least 2.
REQ-002 Parameter HALF_DIV, default 50, sets clk_in cycles per SCLK half-period (1 MHz SCLK from 100 MHz); SHALL be at least 2.
REQ-003 clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  transfer request, sampled each clk_in edge.
REQ-006 tx_data  input  DATA_W  word to transmit, captured on start acceptance.
REQ-007 busy  output  1  high while a transfer is in progress.
REQ-008 rx_data  output  DATA_W  last received word, stable until the next rx_valid.
REQ-009 rx_valid  output  1  one-cycle pulse marking rx_data updated.
REQ-010 sclk, mosi, cs_n  output  1 each  SPI mode-0 clock, data out, active-low chip select.
REQ-011 miso  input  1  SPI data in, MSB first.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, TRANSFER, HOLD.
REQ-013 In IDLE with start=1, next cycle: state=SETUP, busy=1, cs_n=0, tx_data latched, mosi=tx_data[DATA_W-1].
REQ-014 start SHALL be ignored whenever busy=1; no queuing.
REQ-015 SETUP SHALL last HALF_DIV cycles with sclk=0, then enter TRANSFER.
REQ-016 TRANSFER SHALL last 2*DATA_W*HALF_DIV cycles; sclk toggles every HALF_DIV cycles, starting low-to-high.
REQ-017 Each sclk rising edge SHALL shift miso into the receive register LSB-side; each sclk falling edge except the last SHALL advance mosi to the next lower bit.
REQ-018 After the DATA_W-th falling edge, FSM SHALL enter HOLD with sclk=0 and cs_n=0 for HALF_DIV cycles.
REQ-019 On HOLD exit, the same cycle SHALL set cs_n=1, busy=0, mosi=0, rx_valid=1, rx_data=received word; state=IDLE.
REQ-020 A start in the cycle busy falls SHALL be accepted (back-to-back; cs_n high for at least one cycle).
REQ-021 Latency start-accept to rx_valid SHALL be exactly (2*DATA_W+2)*HALF_DIV cycles.
REQ-022 Half-period counter SHALL be $clog2(HALF_DIV) bits wide, wrap to 0 at HALF_DIV-1, and reset to 0 on every state entry.

Reset
REQ-023 On reset: state=IDLE, busy=0, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0, counters=0.
REQ-024 Reset mid-transfer SHALL abort the transfer; no rx_valid pulse.

Configuration
REQ-025 Macro SPI_LOOPBACK_EN defined: internal receive path SHALL take mosi instead of miso; miso ignored.
REQ-026 SPI_LOOPBACK_EN undefined: receive path SHALL use miso; no loopback logic synthesized.

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum typedef and the default DATA_W and HALF_DIV constants.
REQ-028 Sub-module sclk_tick_gen SHALL produce a one-cycle half-period tick from clk_in under an enable, cleared when disabled; spi_master instantiates it once.

Verification
REQ-029 HALF_DIV=4, DATA_W=8, tx_data=0xA5, slave model returns 0x3C on miso -> mosi shows 0xA5 MSB first, rx_data=0x3C, rx_valid exactly 72 cycles after acceptance.
REQ-030 start held high through a transfer -> second transfer begins in the rx_valid cycle; start pulses during busy produce no extra transfers.
REQ-031 reset asserted 20 cycles into a transfer -> next cycle cs_n=1, sclk=0, busy=0; no rx_valid.
REQ-032 SPI_LOOPBACK_EN defined, tx_data=0xC3 -> rx_data=0xC3 regardless of miso.
REQ-033 Count sclk rising edges per transfer -> exactly 8; each sclk level lasts exactly 4 cycles; cs_n low exactly 72 cycles.
REQ-034 tx_data changed during busy -> transmitted word unchanged from the value captured at acceptance.
